// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - frame-buffer pixel fetch port
interface vga_timing_gen_if #(
  parameter int ADDR_BITS  = 20,
  parameter int COLOR_BITS = 3
);
  logic [ADDR_BITS-1:0]  req_addr;
  logic                  req_valid;
  logic [COLOR_BITS-1:0] pixel;

  modport master (output req_addr, output req_valid, input pixel);
  modport slave  (input req_addr, input req_valid, output pixel);
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters, sync generation and delay-matched pixel output
module vga_timing_gen #(
  parameter int H_BITS     = 10,
  parameter int V_BITS     = 10,
  parameter int PORCH_BITS = 8,
  parameter int ADDR_BITS  = 20,
  parameter int COLOR_BITS = 3,
  parameter int RD_LAT     = 1,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0
) (
  input  logic                  clk,
  input  logic                  srst_n,
  input  logic [H_BITS-1:0]     cfg_width,
  input  logic [V_BITS-1:0]     cfg_height,
  input  logic [PORCH_BITS-1:0] cfg_h_fp,
  input  logic [PORCH_BITS-1:0] cfg_h_sync,
  input  logic [PORCH_BITS-1:0] cfg_h_bp,
  input  logic [PORCH_BITS-1:0] cfg_v_fp,
  input  logic [PORCH_BITS-1:0] cfg_v_sync,
  input  logic [PORCH_BITS-1:0] cfg_v_bp,
  input  logic                  cfg_update,
  output logic                  cfg_pending,
  output logic                  cfg_err,
  input  logic [COLOR_BITS-1:0] clear,
  vga_timing_gen_if.master      fb,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  visible,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic [COLOR_BITS-1:0] rgb
);
  localparam int HW = H_BITS + 2;
  localparam int VW = V_BITS + 2;

  typedef struct packed {
    logic [H_BITS-1:0]     w;
    logic [V_BITS-1:0]     h;
    logic [PORCH_BITS-1:0] hfp;
    logic [PORCH_BITS-1:0] hs;
    logic [PORCH_BITS-1:0] hbp;
    logic [PORCH_BITS-1:0] vfp;
    logic [PORCH_BITS-1:0] vs;
    logic [PORCH_BITS-1:0] vbp;
  } cfg_t;

  cfg_t act, pend, cand, cfg_in;

  assign cfg_in = {cfg_width, cfg_height, cfg_h_fp, cfg_h_sync, cfg_h_bp,
                   cfg_v_fp, cfg_v_sync, cfg_v_bp};

  logic [HW-1:0] w_x, hs_start, hs_end, h_total;
  logic [VW-1:0] h_x, vs_start, vs_end, v_total;

  assign w_x      = HW'(act.w);
  assign hs_start = w_x + HW'(act.hfp);
  assign hs_end   = hs_start + HW'(act.hs);
  assign h_total  = hs_end + HW'(act.hbp);
  assign h_x      = VW'(act.h);
  assign vs_start = h_x + VW'(act.vfp);
  assign vs_end   = vs_start + VW'(act.vs);
  assign v_total  = vs_end + VW'(act.vbp);

  logic [HW-1:0]        h_cnt;
  logic [VW-1:0]        v_cnt;
  logic [ADDR_BITS-1:0] addr_cnt;
  logic                 h_last, v_last, frame_wrap;
  logic                 vis0, hs0, vs0, fs0, fe0;

  assign h_last     = (h_cnt == h_total - HW'(1));
  assign v_last     = (v_cnt == v_total - VW'(1));
  assign frame_wrap = h_last && v_last;
  assign vis0       = (h_cnt < w_x) && (v_cnt < h_x);
  assign hs0        = (h_cnt >= hs_start) && (h_cnt < hs_end);
  assign vs0        = (v_cnt >= vs_start) && (v_cnt < vs_end);
  assign fs0        = (h_cnt == '0) && (v_cnt == '0);
  assign fe0        = (h_cnt == w_x) && (v_cnt == h_x - VW'(1));

  assign fb.req_valid = srst_n & vis0;
  assign fb.req_addr  = srst_n ? addr_cnt : '0;

  // A capture on the wrap cycle itself bypasses the pending set.
  logic apply, cand_ok;
  assign cand    = cfg_update ? cfg_in : pend;
  assign apply   = frame_wrap && (cfg_update || cfg_pending);
  assign cand_ok = (cand.w != '0) && (cand.h != '0) && (cand.hs != '0) && (cand.vs != '0);

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      addr_cnt    <= '0;
      act         <= cfg_in;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      h_cnt   <= h_last ? '0 : h_cnt + HW'(1);
      if (h_last)
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      if (frame_wrap)
        addr_cnt <= '0;
      else if (vis0)
        addr_cnt <= addr_cnt + ADDR_BITS'(1);
      if (frame_wrap) begin
        cfg_pending <= 1'b0;
        if (apply) begin
          if (cand_ok)
            act <= cand;
          else
            cfg_err <= 1'b1;
        end
      end else if (cfg_update) begin
        pend        <= cfg_in;
        cfg_pending <= 1'b1;
      end
    end
  end

  // Flags ride alongside the read so they meet the returned pixel.
  logic [4:0] s0, sd;
  assign s0 = {vis0, hs0, vs0, fs0, fe0};

  generate
    if (RD_LAT == 0) begin : g_nolat
      assign sd = s0;
    end else begin : g_lat
      logic [4:0] pipe [RD_LAT];
      always_ff @(posedge clk) begin
        if (!srst_n) begin
          for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= s0;
          for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign sd = pipe[RD_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      rgb         <= clear;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      visible     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      rgb         <= sd[4] ? fb.pixel : '0;
      visible     <= sd[4];
      hsync       <= sd[3] ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= sd[2] ? VSYNC_POL : ~VSYNC_POL;
      frame_start <= sd[1];
      frame_end   <= sd[0];
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen at read latencies 0, 1 and 3
module tb_vga_timing_gen;
  localparam int NDUT = 3;
  localparam int MAXC = 20000;

  typedef struct {int w, h, hfp, hs, hbp, vfp, vs, vbp;} cfg_t;
  typedef struct {bit vis, hs, vs, fs, fe; int addr;} st_t;
  typedef struct {cfg_t cfg; int period; int max_addr; int hs_cnt; int vs_cnt;} vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst_n;
  logic       cfg_update;
  logic [2:0] clear;
  cfg_t       cfg_in;

  logic [9:0] cfg_width, cfg_height;
  logic [7:0] cfg_h_fp, cfg_h_sync, cfg_h_bp, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  assign cfg_width  = 10'(cfg_in.w);
  assign cfg_height = 10'(cfg_in.h);
  assign cfg_h_fp   = 8'(cfg_in.hfp);
  assign cfg_h_sync = 8'(cfg_in.hs);
  assign cfg_h_bp   = 8'(cfg_in.hbp);
  assign cfg_v_fp   = 8'(cfg_in.vfp);
  assign cfg_v_sync = 8'(cfg_in.vs);
  assign cfg_v_bp   = 8'(cfg_in.vbp);

  logic [NDUT-1:0]       pend_o, err_o, hs_o, vs_o, vis_o, fs_o, fe_o, rv_o;
  logic [NDUT-1:0][2:0]  rgb_o;
  logic [NDUT-1:0][19:0] ra_o;

  function automatic logic [2:0] fpix(input logic [19:0] a);
    return a[2:0] ^ 3'b101;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    vga_timing_gen_if #(.ADDR_BITS(20), .COLOR_BITS(3)) fb();
    vga_timing_gen #(
      .H_BITS(10), .V_BITS(10), .PORCH_BITS(8), .ADDR_BITS(20), .COLOR_BITS(3),
      .RD_LAT(LAT), .HSYNC_POL(g != 1), .VSYNC_POL(1'b0)
    ) u_dut (
      .clk(clk), .srst_n(srst_n),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
      .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
      .cfg_update(cfg_update), .cfg_pending(pend_o[g]), .cfg_err(err_o[g]),
      .clear(clear), .fb(fb),
      .hsync(hs_o[g]), .vsync(vs_o[g]), .visible(vis_o[g]),
      .frame_start(fs_o[g]), .frame_end(fe_o[g]), .rgb(rgb_o[g])
    );
    assign rv_o[g] = fb.req_valid;
    assign ra_o[g] = fb.req_addr;
    if (LAT == 0) begin : g_fb_comb
      assign fb.pixel = fpix(fb.req_addr);
    end else begin : g_fb_reg
      logic [2:0] q [LAT];
      always @(posedge clk) begin
        q[0] <= fpix(fb.req_addr);
        for (int i = 1; i < LAT; i++) q[i] <= q[i-1];
      end
      assign fb.pixel = q[LAT-1];
    end
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic bit pol_of(input int d);
    return d != 1;
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act_v, input int exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act_v, exp_v, $time);
    end
  endtask

  // Reference: raster position is simply the cycle offset into the frame.
  cfg_t act, pend;
  bit   pend_f, err_f;
  int   pos, cyc;
  st_t  s_hist [MAXC];
  bit   rst_hist [MAXC];

  function automatic int h_tot(input cfg_t c);
    return c.w + c.hfp + c.hs + c.hbp;
  endfunction

  function automatic int v_tot(input cfg_t c);
    return c.h + c.vfp + c.vs + c.vbp;
  endfunction

  function automatic bit cfg_ok(input cfg_t c);
    return c.w != 0 && c.h != 0 && c.hs != 0 && c.vs != 0;
  endfunction

  function automatic st_t stage0();
    st_t s;
    int h, v;
    h      = pos % h_tot(act);
    v      = pos / h_tot(act);
    s.vis  = h < act.w && v < act.h;
    s.hs   = h >= act.w + act.hfp && h < act.w + act.hfp + act.hs;
    s.vs   = v >= act.h + act.vfp && v < act.h + act.vfp + act.vs;
    s.fs   = pos == 0;
    s.fe   = h == act.w && v == act.h - 1;
    s.addr = (v < act.h) ? v * act.w + ((h < act.w) ? h : act.w) : act.w * act.h;
    return s;
  endfunction

  task automatic model_update();
    if (!srst_n) begin
      act = cfg_in; pos = 0; pend_f = 0; err_f = 0;
    end else begin
      err_f = 0;
      if (pos == h_tot(act) * v_tot(act) - 1) begin
        if (cfg_update || pend_f) begin
          cfg_t c;
          c = cfg_update ? cfg_in : pend;
          if (cfg_ok(c)) act = c;
          else err_f = 1;
        end
        pend_f = 0;
        pos    = 0;
      end else begin
        pos++;
        if (cfg_update) begin
          pend = cfg_in; pend_f = 1;
        end
      end
    end
  endtask

  task automatic tick();
    st_t s, e;
    bit  zero;
    int  src, l;
    s = stage0();
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("req_valid[%0d]", d), rv_o[d], (srst_n && s.vis) ? 1 : 0);
      chk($sformatf("req_addr[%0d]", d), int'(ra_o[d]), srst_n ? s.addr : 0);
    end
    if (cyc >= MAXC - 2) begin
      $display("FAIL cycle_budget actual=%0d expected<%0d", cyc, MAXC - 2);
      $fatal(1, "cycle budget exhausted");
    end
    s_hist[cyc]   = s;
    rst_hist[cyc] = !srst_n;
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      l = lat_of(d);
      chk($sformatf("cfg_pending[%0d]", d), pend_o[d], pend_f);
      chk($sformatf("cfg_err[%0d]", d), err_o[d], err_f);
      if (rst_hist[cyc-1]) begin
        chk($sformatf("rst_rgb[%0d]", d), rgb_o[d], clear);
        chk($sformatf("rst_hsync[%0d]", d), hs_o[d], !pol_of(d));
        chk($sformatf("rst_vsync[%0d]", d), vs_o[d], 1);
        chk($sformatf("rst_visible[%0d]", d), vis_o[d], 0);
        chk($sformatf("rst_fs[%0d]", d), fs_o[d], 0);
        chk($sformatf("rst_fe[%0d]", d), fe_o[d], 0);
      end else begin
        src  = cyc - l - 1;
        zero = 0;
        for (int k = src; k <= cyc - 2; k++)
          if (k >= 0 && rst_hist[k]) zero = 1;
        e = s_hist[src >= 0 ? src : 0];
        if (zero) e = '{0, 0, 0, 0, 0, 0};
        chk($sformatf("rgb[%0d]", d), rgb_o[d], e.vis ? int'(fpix(20'(e.addr))) : 0);
        chk($sformatf("hsync[%0d]", d), hs_o[d], e.hs ? pol_of(d) : !pol_of(d));
        chk($sformatf("vsync[%0d]", d), vs_o[d], e.vs ? 0 : 1);
        chk($sformatf("visible[%0d]", d), vis_o[d], e.vis);
        chk($sformatf("frame_start[%0d]", d), fs_o[d], e.fs);
        chk($sformatf("frame_end[%0d]", d), fe_o[d], e.fe);
      end
    end
  endtask

  function automatic cfg_t rand_cfg(input bit allow_bad);
    cfg_t c;
    c.w = $urandom_range(1, 6);  c.h = $urandom_range(1, 4);
    c.hfp = $urandom_range(0, 2); c.hs = $urandom_range(1, 2); c.hbp = $urandom_range(0, 2);
    c.vfp = $urandom_range(0, 2); c.vs = $urandom_range(1, 2); c.vbp = $urandom_range(0, 2);
    if (allow_bad && $urandom_range(0, 4) == 0) begin
      case ($urandom_range(0, 3))
        0: c.w = 0;
        1: c.h = 0;
        2: c.hs = 0;
        default: c.vs = 0;
      endcase
    end
    return c;
  endfunction

  vec_t tbl [4];
  cfg_t base, wide;
  int   n, per, maxa, hsc, vsc;

  initial begin
    base   = '{4, 2, 1, 1, 1, 1, 1, 1};
    wide   = '{6, 2, 1, 1, 1, 1, 1, 1};
    tbl[0] = '{base, 35, 7, 5, 7};
    tbl[1] = '{wide, 45, 11, 5, 9};
    tbl[2] = '{'{3, 3, 2, 3, 1, 1, 2, 1}, 63, 8, 21, 18};
    tbl[3] = '{'{5, 1, 1, 1, 2, 2, 1, 1}, 45, 4, 5, 9};

    cyc = 0; pos = 0; pend_f = 0; err_f = 0;
    act = base; pend = base;
    srst_n = 1'b0; cfg_update = 1'b0; clear = 3'd6; cfg_in = base;
    repeat (5) tick();
    srst_n = 1'b1;

    // Frame geometry per config, measured on the latency-1 instance.
    for (int r = 0; r < 4; r++) begin
      cfg_in = tbl[r].cfg; cfg_update = 1'b1;
      tick();
      cfg_update = 1'b0;
      n = 0;
      while (pend_o[1] && n < 200) begin tick(); n++; end
      chk("apply_bound", n < 200, 1);
      n = 0;
      while (!fs_o[1] && n < 300) begin tick(); n++; end
      chk("fs_bound", n < 300, 1);
      per = 0; maxa = -1; hsc = 0; vsc = 0;
      do begin
        if (rv_o[1] && int'(ra_o[1]) > maxa) maxa = int'(ra_o[1]);
        if (!hs_o[1]) hsc++;
        if (!vs_o[1]) vsc++;
        per++;
        tick();
      end while (!fs_o[1] && per < 400);
      chk($sformatf("period_row%0d", r), per, tbl[r].period);
      chk($sformatf("max_addr_row%0d", r), maxa, tbl[r].max_addr);
      chk($sformatf("hs_count_row%0d", r), hsc, tbl[r].hs_cnt);
      chk($sformatf("vs_count_row%0d", r), vsc, tbl[r].vs_cnt);
    end

    // Rejected set: height 0.
    cfg_in = base; cfg_in.h = 0; cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0; cfg_in = base;
    n = 0;
    while (!err_o[1] && n < 300) begin tick(); n++; end
    chk("err_seen", err_o[1], 1);
    chk("pending_after_err", pend_o[1], 0);
    tick();
    chk("err_one_cycle", err_o[1], 0);

    // Update landing exactly on the frame-wrap cycle.
    n = 0;
    while (pos != h_tot(act) * v_tot(act) - 1 && n < 400) begin tick(); n++; end
    chk("wrap_bound", n < 400, 1);
    cfg_in = wide; cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    chk("wrap_pending_low", pend_o[1], 0);
    chk("wrap_req_addr0", int'(ra_o[1]), 0);
    repeat (9) tick();
    chk("wrap_new_line1_addr", int'(ra_o[1]), 6);

    // Mid-line reset.
    n = 0;
    while (pos != 3 && n < 400) begin tick(); n++; end
    clear = 3'd5; srst_n = 1'b0;
    tick();
    for (int d = 0; d < NDUT; d++) chk($sformatf("midline_rgb_clear[%0d]", d), rgb_o[d], 5);
    tick();
    srst_n = 1'b1;
    tick();
    chk("restart_addr", int'(ra_o[1]), 1);

    // Randomized traffic with occasional bad sets and resets.
    for (int i = 0; i < 3000; i++) begin
      if (srst_n && $urandom_range(0, 499) == 0) begin
        srst_n = 1'b0; clear = 3'($urandom_range(0, 7));
      end else if (!srst_n && $urandom_range(0, 1) == 0) begin
        srst_n = 1'b1;
      end
      cfg_in     = rand_cfg(srst_n);
      cfg_update = ($urandom_range(0, 39) == 0);
      tick();
    end
    cfg_update = 1'b0;
    srst_n     = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed-width VGA scan generator: raster counters, sync generation and a pixel-fetch request stream to an external frame buffer.
- Adds the following over the previous generation:
  - configurable counter, address and colour widths;
  - frame-synchronous shadowing of runtime timing configuration;
  - configurable sync polarity;
  - a parametrised frame-buffer read latency, with every display output delay-matched to the returned pixel.
- Sits between the frame-buffer read port and the DAC/pin drivers.

Parameters:
- H_BITS, 10, width of horizontal position and width config
- V_BITS, 10, width of vertical position and height config
- PORCH_BITS, 8, width of each porch/sync config field
- ADDR_BITS, 20, width of req_addr
- COLOR_BITS, 3, width of pixel/rgb/clear
- RD_LAT, 1, cycles from req_addr to matching pixel (0 = combinational read)
- HSYNC_POL, 0, active level of hsync
- VSYNC_POL, 0, active level of vsync

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- srst_n  in  1  synchronous active-low reset
- cfg_width  in  H_BITS  visible pixels per line
- cfg_height  in  V_BITS  visible lines per frame
- cfg_h_fp, cfg_h_sync, cfg_h_bp  in  PORCH_BITS each  horizontal front porch, sync and back porch
- cfg_v_fp, cfg_v_sync, cfg_v_bp  in  PORCH_BITS each  vertical equivalents
- cfg_update  in  1  one-cycle pulse: capture cfg_* into the pending set
- cfg_pending  out  1  pending set waiting for a frame boundary
- cfg_err  out  1  one-cycle pulse: pending set rejected at apply
- clear  in  COLOR_BITS  colour driven on rgb while in reset
- req_addr  out  ADDR_BITS  frame-buffer read address
- req_valid  out  1  req_addr is a visible-pixel fetch
- pixel  in  COLOR_BITS  read data, RD_LAT cycles after its req_addr
- hsync, vsync  out  1  sync outputs, polarity per parameter
- visible  out  1  rgb carries frame-buffer data this cycle
- frame_start  out  1  pulse with the first visible pixel of a frame
- frame_end  out  1  pulse on the cycle after the last visible pixel of a frame
- rgb  out  COLOR_BITS  pixel output, registered

Behaviour:
- Reset (srst_n low at a clk edge):
  - h_cnt, v_cnt, addr_cnt, all delay pipes and cfg_pending clear; cfg_err=0.
  - Active config is loaded directly from cfg_*. A cfg_update during reset is ignored.
  - Outputs: rgb=clear; hsync=~HSYNC_POL; vsync=~VSYNC_POL; visible=0; req_valid=0; frame_start=0; frame_end=0; req_addr=0.
- Totals are computed from the active set in H_BITS+2 / V_BITS+2 bits, no truncation:
  - H_TOTAL = W + hfp + hsync + hbp
  - V_TOTAL = H + vfp + vsync + vbp
- Counter stage (stage 0):
  - h_cnt increments every cycle and wraps to 0 at H_TOTAL-1.
  - v_cnt increments on each h wrap and wraps to 0 at V_TOTAL-1.
- Visibility and addressing (stage 0):
  - vis0 = h_cnt < W && v_cnt < H; req_valid = vis0; req_addr = addr_cnt.
  - addr_cnt increments on each vis0 cycle and clears at frame wrap (h=H_TOTAL-1, v=V_TOTAL-1). This gives row-major y*W+x with no multiplier.
- Sync and flags (stage 0):
  - hs0 active when W+hfp <= h_cnt < W+hfp+hsync; vs0 uses the same rule on v_cnt.
  - fs0 = (h=0, v=0); fe0 = (h=W, v=H-1).
- Output alignment:
  - vis0, hs0, vs0, fs0, fe0 pass through an RD_LAT-deep shift register, then one output register.
  - rgb <= vis_d ? pixel : 0 (blanking is black).
  - Every output therefore lags stage 0 by RD_LAT+1 cycles. req_addr/req_valid are not delayed.
- Config shadowing:
  - cfg_update captures cfg_* into the pending set and sets cfg_pending the next cycle.
  - A second cfg_update before apply overwrites the pending set.
  - Apply happens on the frame-wrap cycle: the pending set becomes active for the next counter value (0,0); cfg_pending clears.
  - If cfg_update coincides with the frame-wrap cycle, the just-captured values are applied at that wrap and cfg_pending never rises.
- Validity check at apply:
  - A set with width=0, height=0, hsync=0 or vsync=0 is rejected.
  - On rejection: active set unchanged, cfg_pending clears, cfg_err pulses 1 cycle.
- Config changes never alter timing mid-frame. Mid-frame reset restarts at (0,0) immediately.

Test Plan:
- Reset, W=4, H=2, all porches/syncs=1, RD_LAT=1, pixel=addr[2:0]:
  - H_TOTAL=7, V_TOTAL=5.
  - req_addr 0..3 on line 0 and 4..7 on line 1; req_addr returns to 0 after 35 cycles.
  - rgb lags the matching req by 2 cycles; rgb=0 in blanking.
- Same config: hsync=0 only at h_cnt=5 (delayed 2 cycles); vsync=0 for all of v_cnt=3; frame_start once per 35 cycles; frame_end at output delay after (h=4, v=1).
- cfg_update to W=6 mid-frame:
  - cfg_pending=1 until frame wrap; timing unchanged until then.
  - Next frame has H_TOTAL=9 and req_addr max=11.
- cfg_update pulsed exactly on the frame-wrap cycle -> new set is active at (0,0) and cfg_pending stays 0.
- cfg_update with cfg_height=0 -> at wrap: cfg_err pulses 1 cycle, cfg_pending drops, old timing continues.
- Parameter sweep RD_LAT=0 and RD_LAT=3 with HSYNC_POL=1 -> rgb/sync alignment holds at lag 1 and 4 respectively; hsync active-high; srst_n low mid-line forces rgb=clear and restarts at req_addr=0.
